// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at start into a shadow register and committed to HI/LO
// only when the busy countdown expires, so HI/LO never show a partial update.
// Optional feature macro MD_MADD_EN adds MADD (op 6) and MSUB (op 7), which
// accumulate into {HI,LO} at completion. Without it, ops 6/7 are ignored.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {IDLE, BUSY} state_e;
  // What to do with the shadow value at completion.
  typedef enum logic [1:0] {WB_NONE, WB_LOAD, WB_ADD, WB_SUB} wb_e;

  state_e             state_q, state_d;
  wb_e                mode_q, mode_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // Operand-level arithmetic, evaluated in the start cycle.
  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic [2*WIDTH-1:0]        a_zx, b_zx, prod_u;
  logic [WIDTH-1:0]          b_nz, uq, ur;
  logic signed [WIDTH-1:0]   sq, sr;
  logic                      ovf;
  logic [2*WIDTH-1:0]        div_s, div_u;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_u = a_zx * b_zx;

  // Divisor forced non-zero so the divider never sees 0; the b==0 case is
  // discarded anyway (HI/LO stay unchanged).
  assign b_nz  = (b == '0) ? WIDTH'(1) : b;
  assign sq    = $signed(a) / $signed(b_nz);
  assign sr    = $signed(a) % $signed(b_nz);
  assign uq    = a / b_nz;
  assign ur    = a % b_nz;
  assign ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign div_s = ovf ? {{WIDTH{1'b0}}, a} : {sr, sq};
  assign div_u = {ur, uq};

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] acc;
  // Accumulator samples the current {HI,LO} at completion, wrapping mod 2^(2W).
  assign acc = (mode_q == WB_SUB) ? ({hi_q, lo_q} - sh_q) : ({hi_q, lo_q} + sh_q);
`endif

  // Next-state: accept in IDLE, count down in BUSY, commit on reaching zero.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start) begin
        case (op)
          3'd0: begin sh_d = prod_s; mode_d = WB_LOAD; cnt_d = MULT_N; state_d = BUSY; end
          3'd1: begin sh_d = prod_u; mode_d = WB_LOAD; cnt_d = MULT_N; state_d = BUSY; end
          3'd2: begin
            sh_d = div_s; mode_d = (b == '0) ? WB_NONE : WB_LOAD;
            cnt_d = DIV_N; state_d = BUSY;
          end
          3'd3: begin
            sh_d = div_u; mode_d = (b == '0) ? WB_NONE : WB_LOAD;
            cnt_d = DIV_N; state_d = BUSY;
          end
          3'd4: hi_d = a;
          3'd5: lo_d = a;
`ifdef MD_MADD_EN
          3'd6: begin sh_d = prod_s; mode_d = WB_ADD; cnt_d = MULT_N; state_d = BUSY; end
          3'd7: begin sh_d = prod_s; mode_d = WB_SUB; cnt_d = MULT_N; state_d = BUSY; end
`endif
          default: ;
        endcase
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          case (mode_q)
            WB_LOAD: {hi_d, lo_d} = sh_q;
`ifdef MD_MADD_EN
            WB_ADD, WB_SUB: {hi_d, lo_d} = acc;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= WB_NONE;
      cnt_q   <= '0;
      sh_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed cases plus randomized ops against an
// arithmetic reference model of HI/LO and expected busy length.
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: apply one op to the architectural HI/LO model.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int nbusy);
    longint      ps;
    logic [63:0] pu;
    int          xi, yi;
    xi = x; yi = y;
    ps = longint'(xi) * longint'(yi);
    pu = {32'd0, x} * {32'd0, y};
    nbusy = 0;
    case (o)
      3'd0: begin {hi_m, lo_m} = ps; nbusy = 5; end
      3'd1: begin {hi_m, lo_m} = pu; nbusy = 5; end
      3'd2: begin
        nbusy = 10;
        if (y != 0) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo_m = x; hi_m = 0; end
          else begin lo_m = xi / yi; hi_m = xi % yi; end
        end
      end
      3'd3: begin nbusy = 10; if (y != 0) begin lo_m = x / y; hi_m = x % y; end end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      default: begin
`ifdef MD_MADD_EN
        nbusy = 5;
        if (o == 3'd6) {hi_m, lo_m} = {hi_m, lo_m} + ps;
        else           {hi_m, lo_m} = {hi_m, lo_m} - ps;
`endif
      end
    endcase
  endtask

  // Issue one op, count busy cycles, check hold during busy and final HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string name);
    int nexp, n;
    logic [31:0] oh, ol;
    oh = hi_m; ol = lo_m;
    model(o, x, y, nexp);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      checks++;
      if (hi !== oh || lo !== ol) begin
        errors++;
        $display("FAIL %s hold: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, oh, ol);
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== nexp) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, nexp);
    end
    checks++;
    if (hi !== hi_m || lo !== lo_m) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    reset = 1'b0;
    hi_m = 0; lo_m = 0;
  endtask

  task automatic test_directed;
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mult_const: hi=%h lo=%h expected ffffffff/ffffffeb", hi, lo);
    end
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, "multu");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_const: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    run_op(3'd3, 32'd7, 32'd2, "divu");
    run_op(3'd4, 32'd5, 32'd0, "mthi");
    run_op(3'd2, 32'd9, 32'd0, "div_by_zero");
    checks++;
    if (hi !== 32'd5 || lo !== 32'd3) begin
      errors++;
      $display("FAIL dbz_const: hi=%h lo=%h expected 5/3", hi, lo);
    end
    run_op(3'd5, 32'd8, 32'd0, "mtlo");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd3, 32'h1234_5678, 32'd0, "divu_by_zero");
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 5));
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = 32'hFFFF_FFFF;
        2: y = 32'($urandom_range(1, 16));
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      run_op(o, x, y, "random");
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk); start = 1'b0;
    n = 0;
    repeat (2) begin if (busy === 1'b1) n++; @(negedge clk); end
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    if (busy === 1'b1) n++;
    @(negedge clk); start = 1'b0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    hi_m = 32'd0; lo_m = 32'd12;
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL start_while_busy cycles: got %0d expected 5", n);
    end
    checks++;
    if (hi !== hi_m || lo !== lo_m) begin
      errors++;
      $display("FAIL start_while_busy result: hi=%h lo=%h expected %h/%h", hi, lo, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_mid;
    run_op(3'd4, 32'hAAAA_5555, 32'd0, "pre_mthi");
    run_op(3'd5, 32'h1357_9BDF, 32'd0, "pre_mtlo");
    @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    hi_m = 0; lo_m = 0;
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_after: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_madd;
`ifdef MD_MADD_EN
    run_op(3'd4, 32'd0, 32'd0, "madd_pre_hi");
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, "madd_pre_lo");
    run_op(3'd6, 32'd1, 32'd1, "madd");
    checks++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errors++;
      $display("FAIL madd_const: hi=%h lo=%h expected 1/0", hi, lo);
    end
    run_op(3'd7, 32'hFFFF_FFFE, 32'd3, "msub");
    for (int i = 0; i < 6; i++) run_op(3'(6 + (i % 2)), $urandom, $urandom, "madd_rand");
`else
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, "rsv_pre_hi");
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, "rsv_pre_lo");
    run_op(3'd6, 32'd1, 32'd1, "reserved6");
    run_op(3'd7, 32'd3, 32'd5, "reserved7");
    run_op(3'd0, 32'd6, 32'd7, "after_reserved");
`endif
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
